// File: rtl/sume_to_sdnet_tuple_gen.sv
// rtl/sume_to_sdnet_tuple_gen.sv - SUME AXI-Stream handshake to SDNet tuple strobe, with length/overlong/count stats
module sume_to_sdnet_tuple_gen #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_TUPLE_MODE         = 0,
  parameter int C_MAX_BEATS          = 64,
  parameter int C_CNT_WIDTH          = 32
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic                            SUME_axis_tvalid,
  input  logic                            SUME_axis_tready,
  input  logic                            SUME_axis_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] SUME_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] SUME_axis_tuser,
  input  logic                            clear_counters,
  output logic                            SDNet_tuple_VALID,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0] SDNet_tuple_DATA,
  output logic                            SDNet_axis_TLAST,
  output logic [15:0]                     pkt_len,
  output logic                            pkt_len_valid,
  output logic                            pkt_err_overlong,
  output logic [C_CNT_WIDTH-1:0]          pkt_count
);

  localparam int BPB     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int BPB_LOG = $clog2(BPB);
  localparam int PW      = $clog2(BPB + 1);

  typedef enum logic {ST_FIRST, ST_WAIT} state_t;

  state_t                          state;
  logic [15:0]                     beat_cnt;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuple_data_q;
  logic                            tuple_valid_q;

  logic        acc;
  logic        first_acc;
  logic        last_acc;
  logic [PW-1:0] keep_bytes;
  logic [15:0] beats_before;
  logic [16:0] total_beats;
  logic [31:0] len_full;
  logic [15:0] len_sat;
  logic        overlong;

  assign acc       = SUME_axis_tvalid & SUME_axis_tready;
  assign first_acc = acc & (state == ST_FIRST);
  assign last_acc  = acc & SUME_axis_tlast;

  // Byte count of the last beat: every set keep bit counts, holes included.
  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < BPB; i++) begin
      keep_bytes = keep_bytes + PW'(SUME_axis_tkeep[i]);
    end
  end

  assign beats_before = (state == ST_FIRST) ? 16'd0 : beat_cnt;
  assign total_beats  = {1'b0, beats_before} + 17'd1;
  assign len_full     = (32'(beats_before) << BPB_LOG) + 32'(keep_bytes);
  assign len_sat      = (|len_full[31:16]) ? 16'hFFFF : len_full[15:0];
  assign overlong     = total_beats > 17'(C_MAX_BEATS);

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state            <= ST_FIRST;
      beat_cnt         <= '0;
      tuple_data_q     <= '0;
      tuple_valid_q    <= 1'b0;
      pkt_len          <= '0;
      pkt_len_valid    <= 1'b0;
      pkt_err_overlong <= 1'b0;
      pkt_count        <= '0;
    end else begin
      tuple_valid_q    <= (C_TUPLE_MODE != 0) && last_acc;
      pkt_len_valid    <= last_acc;
      pkt_err_overlong <= last_acc & overlong;

      if (first_acc) begin
        beat_cnt     <= 16'd1;
        tuple_data_q <= SUME_axis_tuser;
      end else if (acc && beat_cnt != 16'hFFFF) begin
        beat_cnt <= beat_cnt + 16'd1;
      end

      if (last_acc) begin
        pkt_len <= len_sat;
      end

      case (state)
        ST_FIRST: if (acc && !SUME_axis_tlast) state <= ST_WAIT;
        ST_WAIT:  if (last_acc) state <= ST_FIRST;
        default:  state <= ST_FIRST;
      endcase

      // A clear in the same cycle as a completion wins; that packet is dropped from the count.
      if (clear_counters) begin
        pkt_count <= '0;
      end else if (last_acc) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

  assign SDNet_axis_TLAST  = SUME_axis_tvalid & SUME_axis_tlast;
  assign SDNet_tuple_VALID = (C_TUPLE_MODE == 0) ? first_acc : tuple_valid_q;
  assign SDNet_tuple_DATA  = (C_TUPLE_MODE == 0) ? SUME_axis_tuser : tuple_data_q;

endmodule
